// File: rtl/alu_if.sv
// Operand/opcode/flag bundle between a datapath controller and the alu.
// The tri-stated result bus stays a plain port on the alu.
interface alu_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] in_A;
   logic [WIDTH-1:0] in_B;
   logic [2:0]       op;
   logic             in_enable_out;
   logic [3:0]       flags;

   modport master (
      output in_A,
      output in_B,
      output op,
      output in_enable_out,
      input  flags
   );

   modport slave (
      input  in_A,
      input  in_B,
      input  op,
      input  in_enable_out,
      output flags
   );
endinterface

// File: rtl/alu.sv
// Registered 8-op ALU with C/N/O/Z flags and a tri-stated result bus.
// Optional: define ALU_SHIFT_CARRY_EN to report the shifted-out bit in C for SHR/SHL.
module alu #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_if.slave             bus,
   output wire [WIDTH-1:0]  out
);
   localparam int unsigned MSB = WIDTH - 1;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_OR  = 3'd2,
      OP_AND = 3'd3,
      OP_NOT = 3'd4,
      OP_CMP = 3'd5,
      OP_SHR = 3'd6,
      OP_SHL = 3'd7
   } op_e;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH:0]   diff_ext;
   logic [WIDTH-1:0] res_d;
   logic             c_d;
   logic             n_d;
   logic             o_d;
   logic             z_d;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;

   assign a        = bus.in_A;
   assign b        = bus.in_B;
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   // Bit WIDTH of the zero-extended difference is the unsigned borrow.
   assign diff_ext = {1'b0, a} - {1'b0, b};

   // Next result and flags for the selected operation
   always_comb begin
      res_d = '0;
      c_d   = 1'b0;
      o_d   = 1'b0;
      n_d   = 1'b0;
      z_d   = 1'b0;
      case (op_e'(bus.op))
         OP_ADD: begin
            res_d = sum_ext[MSB:0];
            c_d   = sum_ext[WIDTH];
            o_d   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
         end
         OP_SUB, OP_CMP: begin
            res_d = diff_ext[MSB:0];
            c_d   = diff_ext[WIDTH];
            o_d   = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
         end
         OP_OR:  res_d = a | b;
         OP_AND: res_d = a & b;
         OP_NOT: res_d = ~a;
         OP_SHR: begin
            res_d = {1'b0, a[MSB:1]};
`ifdef ALU_SHIFT_CARRY_EN
            c_d   = a[0];
`endif
         end
         OP_SHL: begin
            res_d = {a[MSB-1:0], 1'b0};
`ifdef ALU_SHIFT_CARRY_EN
            c_d   = a[MSB];
`endif
         end
         default: res_d = '0;
      endcase
      // N/Z always follow the computed value; CMP then keeps A as the stored result.
      n_d = res_d[MSB];
      z_d = (res_d == '0);
      if (op_e'(bus.op) == OP_CMP) begin
         res_d = a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         flags_q  <= 4'b0000;
      end else begin
         result_q <= res_d;
         flags_q  <= {c_d, n_d, o_d, z_d};
      end
   end

   assign bus.flags = flags_q;
   assign out       = bus.in_enable_out ? result_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed plan vectors plus random ops against an integer model.
module tb_alu;
   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   wire [WIDTH-1:0]  out;

   alu_if #(.WIDTH(WIDTH)) bus ();

   alu #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .out   (out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] res;
      logic [3:0] flags;
   } exp_t;

   exp_t exp_q[$];
   exp_t last;
   int   total = 0;
   int   bad   = 0;

   // Reference built from signed/unsigned integer arithmetic
   function automatic exp_t model(input int a, input int b, input int op);
      exp_t e;
      int   r  = 0;
      int   t  = 0;
      int   c  = 0;
      int   o  = 0;
      int   sa = (a >= 128) ? a - 256 : a;
      int   sb = (b >= 128) ? b - 256 : b;
      int   sr = 0;
      int   carry_en = 0;
`ifdef ALU_SHIFT_CARRY_EN
      carry_en = 1;
`endif
      case (op)
         0: begin
            t = a + b; r = t % 256; c = (t >= 256) ? 1 : 0;
            sr = sa + sb; o = (sr > 127 || sr < -128) ? 1 : 0;
         end
         1, 5: begin
            t = a - b; r = (t + 256) % 256; c = (a < b) ? 1 : 0;
            sr = sa - sb; o = (sr > 127 || sr < -128) ? 1 : 0;
         end
         2: r = a | b;
         3: r = a & b;
         4: r = 255 - a;
         6: begin r = a / 2;         c = carry_en ? a % 2 : 0;   end
         7: begin r = (a * 2) % 256; c = carry_en ? a / 128 : 0; end
         default: r = 0;
      endcase
      e.a     = 8'(a);
      e.b     = 8'(b);
      e.op    = 3'(op);
      e.res   = (op == 5) ? 8'(a) : 8'(r);
      e.flags = {1'(c), 1'(r >= 128 ? 1 : 0), 1'(o), 1'(r == 0 ? 1 : 0)};
      return e;
   endfunction

   task automatic issue(input int a, input int b, input int op);
      @(negedge clk);
      bus.in_A = 8'(a);
      bus.in_B = 8'(b);
      bus.op   = 3'(op);
      exp_q.push_back(model(a, b, op));
   endtask

   task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      total++;
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: every capture edge with a pending expectation is compared
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (out !== e.res || bus.flags !== e.flags) begin
               bad++;
               $display("FAIL op%0d A=%h B=%h: got out=%h flags=%b want out=%h flags=%b",
                        e.op, e.a, e.b, out, bus.flags, e.res, e.flags);
            end
            last = e;
         end
      end
   end

   int da[17] = '{8'h40, 8'h84, 8'h40, 8'h01, 8'h01, 8'h80, 8'h81, 8'h03, 8'h53, 8'h53,
                  8'h53, 8'h53, 8'h53, 8'h53, 8'h00, 8'hFF, 8'h80};
   int db[17] = '{8'h41, 8'h81, 8'hC0, 8'h02, 8'h80, 8'h01, 8'h81, 8'h11, 8'h11, 8'h00,
                  8'h52, 8'h53, 8'h00, 8'h00, 8'h00, 8'h01, 8'h80};
   int dop[17] = '{0, 0, 0, 1, 1, 1, 1, 2, 3, 4, 5, 5, 6, 7, 1, 0, 7};

   initial begin
      bus.in_A = '0;
      bus.in_B = '0;
      bus.op   = '0;
      bus.in_enable_out = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("reset_out", {4'h0, out}, 12'h000);
      chk("reset_flags", {8'h00, bus.flags}, 12'h000);
      bus.in_A = 8'h01;
      bus.in_B = 8'h01;
      @(posedge clk);
      #1;
      chk("no_capture_in_reset", {bus.flags, out}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) issue(da[i], db[i], dop[i]);
      for (int i = 0; i < 300; i++)
         issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
      drain();

      // Enable toggling between edges must not disturb stored state
      @(negedge clk);
      bus.in_enable_out = 1'b0;
      #1;
      total++;
      if (out !== 8'hzz) begin
         bad++;
         $display("FAIL out_disabled: got %h want zz", out);
      end
      chk("flags_while_disabled", {8'h00, bus.flags}, {8'h00, last.flags});
      bus.in_enable_out = 1'b1;
      #1;
      chk("out_reenabled", {4'h0, out}, {4'h0, last.res});

      issue(8'h40, 8'h41, 0);
      issue(8'hFF, 8'hFF, 4);
      drain();

      // Asynchronous reset mid-sequence, no clock edge needed
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_reset_flags", {8'h00, bus.flags}, 12'h000);
      chk("async_reset_out", {4'h0, out}, 12'h000);
      bus.in_enable_out = 1'b0;
      #1;
      total++;
      if (out !== 8'hzz) begin
         bad++;
         $display("FAIL reset_disabled: got %h want zz", out);
      end
      bus.in_enable_out = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 40; i++)
         issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
